// File: rtl/softmax_q412_pkg.sv
// Shared Q4.12 constants for the softmax datapath stages.
package softmax_q412_pkg;

    localparam int unsigned Q_FRAC = 12;
    localparam int unsigned Q_INT  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned POS_W  = 4;

    localparam logic [DATA_W-1:0] LOG_SAT_VAL = 16'h8000;

    // Nearest Q4.12 encoding of a non-negative real; for benches only.
    function automatic logic [DATA_W-1:0] to_q412(input real r);
        return DATA_W'($rtoi(r * real'(1 << Q_FRAC) + 0.5));
    endfunction

endpackage

// File: rtl/lod16.sv
// Leading-one detector: index of the highest set bit, pos = 0 when x = 0.
module lod16
    import softmax_q412_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    output logic [POS_W-1:0]  pos,
    output logic              zero
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        pos  = '0;
        zero = (x == '0);
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (x[i]) begin
                pos = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/stage_log2_approx.sv
// Three-stage log2 approximation of an unsigned Q4.12 value into signed Q4.12.
// log2(2^p * (1+f)) ~= (p-12) + f, with the mantissa taken linearly.
module stage_log2_approx
    import softmax_q412_pkg::*;
#(
    parameter int unsigned TAG_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] in_x,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              valid_out,
    output logic [DATA_W-1:0] log_x,
    output logic [TAG_W-1:0]  tag_out,
    output logic              sat_out,
    output logic              zero_out
);

    localparam logic [POS_W-1:0] INT_BIAS = POS_W'(Q_FRAC);
    localparam logic [POS_W-1:0] MIN_POS  = POS_W'(4);
    localparam logic [POS_W-1:0] TOP_POS  = POS_W'(DATA_W - 1);

    // S0: input capture
    logic              v0_q;
    logic [DATA_W-1:0] x0_q;
    logic [TAG_W-1:0]  tag0_q;

    // S1: leading-one position alongside the operand
    logic              v1_q;
    logic [DATA_W-1:0] x1_q;
    logic [TAG_W-1:0]  tag1_q;
    logic [POS_W-1:0]  p1_q;
    logic              zero1_q;
    logic [POS_W-1:0]  p1_d;
    logic              zero1_d;

    // S2: output registers
    logic              v2_q;
    logic [DATA_W-1:0] log2_q;
    logic [TAG_W-1:0]  tag2_q;
    logic              sat2_q;
    logic              zero2_q;
    logic [DATA_W-1:0] log2_d;
    logic              sat2_d;

    logic [DATA_W-1:0] norm_c;
    logic [Q_FRAC-1:0] frac_c;
    logic [POS_W-1:0]  int_c;

    lod16 u_lod16 (
        .x    (x0_q),
        .pos  (p1_d),
        .zero (zero1_d)
    );

    // Normalise so the leading one lands on bit 15; the 12 bits below it are f.
    always_comb begin
        norm_c = x1_q << (TOP_POS - p1_q);
        frac_c = Q_FRAC'(norm_c >> 3);
        int_c  = p1_q - INT_BIAS;
        sat2_d = zero1_q | (p1_q < MIN_POS);
        log2_d = sat2_d ? LOG_SAT_VAL : {int_c, frac_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q    <= 1'b0;
            x0_q    <= '0;
            tag0_q  <= '0;
            v1_q    <= 1'b0;
            x1_q    <= '0;
            tag1_q  <= '0;
            p1_q    <= '0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            log2_q  <= '0;
            tag2_q  <= '0;
            sat2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else if (en) begin
            v0_q    <= valid_in;
            x0_q    <= in_x;
            tag0_q  <= in_tag;
            v1_q    <= v0_q;
            x1_q    <= x0_q;
            tag1_q  <= tag0_q;
            p1_q    <= p1_d;
            zero1_q <= zero1_d;
            v2_q    <= v1_q;
            log2_q  <= log2_d;
            tag2_q  <= tag1_q;
            sat2_q  <= sat2_d;
            zero2_q <= zero1_q;
        end
    end

    assign valid_out = v2_q;
    assign log_x     = log2_q;
    assign tag_out   = tag2_q;
    assign sat_out   = sat2_q;
    assign zero_out  = zero2_q;

endmodule
